reaction_test_ctrl: RTL

Sequencer for the board's reaction-time test. It runs the 3-2-1 countdown and then a blank display period whose end is set by a random millisecond value from the LFSR delay generator. It then lights GO and measures the operator's reaction in milliseconds. It also flags false starts and timeouts, and feeds the seven-segment display driver and LEDs.

---
 rtl/reaction_test_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/reaction_test_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_test_ctrl
//
// Sequencer for the reaction-time test. It runs a 3-2-1 countdown (1 s per
// digit) and then a blank display period. The blank period ends when the
// elapsed time reaches a latched random delay, which is never less than
// MIN_DELAY_MS. It then shows GO and measures the operator's reaction in ms.
// A press during the countdown or blank period is flagged as a false start.
// No press within MAX_RT_MS is flagged as a timeout.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      single-cycle start pulse; honoured only in IDLE, DONE or EARLY
//   react      debounced reaction button (level); rising edges are presses
//   rand_ms    random delay in ms, sampled when start is accepted
//   state_o    IDLE=0, COUNT=1, BLANK=2, GO=3, DONE=4, EARLY=5
//   digit_o    countdown digit 3/2/1, 0 outside COUNT
//   blank_o    high in BLANK
//   go_o       high in GO
//   rt_ms      measured reaction time in ms (MAX_RT_MS after a timeout)
//   rt_valid   high in DONE when rt_ms is a real measurement
//   timeout_o  high in DONE after a timeout
//   early_o    high in EARLY
//   best_ms    best valid reaction time since reset
//
// Build option
//   BEST_TIME_EN  when defined, best_ms tracks the minimum valid reaction time.
//                 The register resets to 14'h3FFF. When undefined, best_ms is
//                 tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module reaction_test_ctrl #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 4000,
  parameter int MAX_RT_MS    = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        react,
  input  logic [12:0] rand_ms,
  output logic [2:0]  state_o,
  output logic [1:0]  digit_o,
  output logic        blank_o,
  output logic        go_o,
  output logic [13:0] rt_ms,
  output logic        rt_valid,
  output logic        timeout_o,
  output logic        early_o,
  output logic [13:0] best_ms
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_BLANK = 3'd2,
    S_GO    = 3'd3,
    S_DONE  = 3'd4,
    S_EARLY = 3'd5
  } state_t;

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]   MIN_DLY    = 14'(MIN_DELAY_MS);
  localparam logic [13:0]   MAX_RT     = 14'(MAX_RT_MS);
  localparam logic [13:0]   COUNT_END  = 14'd3000;

  state_t      state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [13:0] elapsed_q, elapsed_d, elapsed_inc;
  logic [13:0] delay_q, delay_d;
  logic [13:0] rt_q, rt_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        react_q;
  logic [1:0]  digit_q, digit_d;
  logic        blank_q, go_q, early_q;
  logic        tick, press;

  // A press is a rising edge against the registered copy. This means a button
  // already held when a state is entered does not count as a press.
  assign press       = react & ~react_q;
  assign tick        = (presc_q == PRESC_LAST);
  assign elapsed_inc = elapsed_q + {13'd0, tick};

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    elapsed_d = elapsed_q;
    delay_d   = delay_q;
    rt_d      = rt_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    digit_d   = 2'd0;

    unique case (state_q)
      S_IDLE, S_DONE, S_EARLY: begin
        if (start) begin
          state_d   = S_COUNT;
          delay_d   = ({1'b0, rand_ms} < MIN_DLY) ? MIN_DLY : {1'b0, rand_ms};
          presc_d   = '0;
          elapsed_d = '0;
          rt_d      = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_COUNT, S_BLANK, S_GO: begin
        presc_d   = tick ? '0 : presc_q + 1'b1;
        elapsed_d = elapsed_inc;
        if (state_q == S_GO) begin
          // A press wins over a timeout in the same cycle.
          if (press) begin
            state_d = S_DONE;
            rt_d    = elapsed_q;
            valid_d = 1'b1;
          end else if (elapsed_inc >= MAX_RT) begin
            state_d   = S_DONE;
            rt_d      = MAX_RT;
            timeout_d = 1'b1;
          end
        end else if (press) begin
          // A false start wins over a same-cycle COUNT->BLANK or BLANK->GO step.
          state_d = S_EARLY;
        end else if (state_q == S_COUNT) begin
          if (elapsed_inc >= COUNT_END) state_d = S_BLANK;
        end else if (elapsed_inc >= delay_q) begin
          // Measure the reaction from a fresh ms boundary.
          state_d   = S_GO;
          presc_d   = '0;
          elapsed_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_COUNT) begin
      if (elapsed_d < 14'd1000)      digit_d = 2'd3;
      else if (elapsed_d < 14'd2000) digit_d = 2'd2;
      else                           digit_d = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      elapsed_q <= '0;
      delay_q   <= '0;
      rt_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      react_q   <= 1'b0;
      digit_q   <= 2'd0;
      blank_q   <= 1'b0;
      go_q      <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      delay_q   <= delay_d;
      rt_q      <= rt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      react_q   <= react;
      digit_q   <= digit_d;
      blank_q   <= (state_d == S_BLANK);
      go_q      <= (state_d == S_GO);
      early_q   <= (state_d == S_EARLY);
    end
  end

  assign state_o   = state_q;
  assign digit_o   = digit_q;
  assign blank_o   = blank_q;
  assign go_o      = go_q;
  assign rt_ms     = rt_q;
  assign rt_valid  = valid_q;
  assign timeout_o = timeout_q;
  assign early_o   = early_q;

`ifdef BEST_TIME_EN
  logic [13:0] best_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= 14'h3FFF;
    end else if (state_q == S_GO && state_d == S_DONE && valid_d && rt_d < best_q) begin
      best_q <= rt_d;
    end
  end
  assign best_ms = best_q;
`else
  assign best_ms = 14'd0;
`endif

endmodule
